// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller: hit/miss decision,
// single-word refill handshake and full valid-bit sweep on flush.
module icache_ctrl #(
  parameter int unsigned INDEX_LENGTH = 5,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned TAG_LENGTH   = ADDR_WIDTH - INDEX_LENGTH - 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    core_req,
  input  logic [ADDR_WIDTH-1:0]   core_addr,
  output logic                    core_wait,
  output logic [31:0]             core_rdata,
  input  logic                    flush,
  output logic                    flush_busy,
  output logic [INDEX_LENGTH-1:0] ram_index,
  output logic                    valid_w_en,
  output logic                    valid_in,
  input  logic                    valid_out,
  output logic                    tag_w_en,
  output logic [TAG_LENGTH-1:0]   tag_in,
  input  logic [TAG_LENGTH-1:0]   tag_out,
  output logic                    data_w_en,
  output logic [31:0]             data_in,
  input  logic [31:0]             data_out,
  output logic                    mem_req,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic                    mem_ack,
  input  logic [31:0]             mem_rdata
);

  localparam int unsigned WORD_W = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, MISS, RESP, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [INDEX_LENGTH-1:0] cnt_q, cnt_d;
  logic                    pend_q, pend_d;
  logic [WORD_W-1:0]       miss_word_q, miss_word_d;
  logic [31:0]             rbuf_q, rbuf_d;

  logic [INDEX_LENGTH-1:0] req_index;
  logic [TAG_LENGTH-1:0]   req_tag;
  logic [INDEX_LENGTH-1:0] miss_index;
  logic [TAG_LENGTH-1:0]   miss_tag;
  logic                    hit;
  logic                    unused_addr_bits;

  assign req_index        = core_addr[INDEX_LENGTH+1:2];
  assign req_tag          = TAG_LENGTH'(core_addr[ADDR_WIDTH-1:INDEX_LENGTH+2]);
  assign miss_index       = miss_word_q[INDEX_LENGTH-1:0];
  assign miss_tag         = TAG_LENGTH'(miss_word_q[WORD_W-1:INDEX_LENGTH]);
  assign hit              = valid_out & (tag_out == req_tag);
  assign unused_addr_bits = ^core_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      miss_word_q <= '0;
      rbuf_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      miss_word_q <= miss_word_d;
      rbuf_q      <= rbuf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    miss_word_d = miss_word_q;
    rbuf_d      = rbuf_q;
    core_wait   = 1'b0;
    core_rdata  = '0;
    flush_busy  = 1'b0;
    ram_index   = req_index;
    valid_w_en  = 1'b0;
    valid_in    = 1'b0;
    tag_w_en    = 1'b0;
    tag_in      = miss_tag;
    data_w_en   = 1'b0;
    data_in     = mem_rdata;
    mem_req     = 1'b0;
    mem_addr    = {miss_word_q, 2'b00};

    unique case (state_q)
      IDLE: begin
        // A pending or fresh flush takes priority over any fetch
        if (flush || pend_q) begin
          state_d   = FLUSH;
          cnt_d     = '0;
          pend_d    = 1'b0;
          core_wait = core_req;
        end else if (core_req) begin
          if (hit) begin
            core_rdata = data_out;
          end else begin
            miss_word_d = core_addr[ADDR_WIDTH-1:2];
            core_wait   = 1'b1;
            state_d     = MISS;
          end
        end
      end
      MISS: begin
        ram_index = miss_index;
        mem_req   = 1'b1;
        core_wait = 1'b1;
        if (flush) pend_d = 1'b1;
        if (mem_ack) begin
          valid_w_en = 1'b1;
          valid_in   = 1'b1;
          tag_w_en   = 1'b1;
          data_w_en  = 1'b1;
          rbuf_d     = mem_rdata;
          state_d    = RESP;
        end
      end
      RESP: begin
        ram_index  = miss_index;
        core_rdata = rbuf_q;
        if (flush) pend_d = 1'b1;
        state_d    = IDLE;
      end
      FLUSH: begin
        // Further flush pulses are absorbed; the sweep never restarts
        ram_index  = cnt_q;
        valid_w_en = 1'b1;
        flush_busy = 1'b1;
        core_wait  = core_req;
        cnt_d      = cnt_q + INDEX_LENGTH'(1);
        if (&cnt_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed self-checking bench for icache_ctrl with behavioural valid/tag/data
// RAMs and a hand-driven refill memory port.
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic [31:0] core_addr;
  logic        core_wait;
  logic [31:0] core_rdata;
  logic        flush;
  logic        flush_busy;
  logic [4:0]  ram_index;
  logic        valid_w_en, valid_in, valid_out;
  logic        tag_w_en;
  logic [24:0] tag_in, tag_out;
  logic        data_w_en;
  logic [31:0] data_in, data_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int data_wr_cnt = 0;
  logic [4:0] flush_q[$];

  always #5 clk = ~clk;

  icache_ctrl dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_addr(core_addr),
    .core_wait(core_wait), .core_rdata(core_rdata),
    .flush(flush), .flush_busy(flush_busy),
    .ram_index(ram_index),
    .valid_w_en(valid_w_en), .valid_in(valid_in), .valid_out(valid_out),
    .tag_w_en(tag_w_en), .tag_in(tag_in), .tag_out(tag_out),
    .data_w_en(data_w_en), .data_in(data_in), .data_out(data_out),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Line RAMs: combinational read, write on clock edge, valid cleared by reset
  logic        v_mem[32];
  logic [24:0] t_mem[32];
  logic [31:0] d_mem[32];

  initial begin
    for (int i = 0; i < 32; i++) begin
      t_mem[i] = '0;
      d_mem[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) v_mem[i] <= 1'b0;
    end else if (valid_w_en) begin
      v_mem[ram_index] <= valid_in;
    end
  end

  always @(posedge clk) begin
    if (tag_w_en)  t_mem[ram_index] <= tag_in;
    if (data_w_en) d_mem[ram_index] <= data_in;
    if (data_w_en) data_wr_cnt++;
    if (valid_w_en && !valid_in) flush_q.push_back(ram_index);
  end

  assign valid_out = v_mem[ram_index];
  assign tag_out   = t_mem[ram_index];
  assign data_out  = d_mem[ram_index];

  task automatic test_reset();
    #1;
    checks++;
    if (core_wait !== 1'b0 || mem_req !== 1'b0 || flush_busy !== 1'b0 ||
        valid_w_en !== 1'b0 || tag_w_en !== 1'b0 || data_w_en !== 1'b0 ||
        core_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: wait=%b req=%b busy=%b we=%b%b%b rdata=%h, required all 0",
               core_wait, mem_req, flush_busy, valid_w_en, tag_w_en, data_w_en, core_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (core_wait !== 1'b0 || mem_req !== 1'b0 || flush_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: wait=%b req=%b busy=%b, required 0 0 0",
               core_wait, mem_req, flush_busy);
    end
  endtask

  // Full miss: request, refill after ack_delay stalled cycles, RESP delivery
  task automatic do_miss(input logic [31:0] addr, input logic [31:0] data,
                         input int ack_delay, input int flush_at, input string name);
    int wr0;
    wr0 = data_wr_cnt;
    @(negedge clk);
    core_req  = 1'b1;
    core_addr = addr;
    flush     = 1'b0;
    #1;
    checks++;
    if (core_wait !== 1'b1 || mem_req !== 1'b0 || ram_index !== addr[6:2]) begin
      errors++;
      $display("FAIL %s_detect: wait=%b mem_req=%b index=%0d, required 1 0 %0d",
               name, core_wait, mem_req, ram_index, addr[6:2]);
    end
    for (int k = 1; k <= ack_delay + 1; k++) begin
      @(negedge clk);
      flush     = (k == flush_at);
      mem_ack   = (k == ack_delay + 1);
      mem_rdata = mem_ack ? data : (32'hBAD0_0000 | 32'(k));
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== {addr[31:2], 2'b00} || core_wait !== 1'b1) begin
        errors++;
        $display("FAIL %s_miss_c%0d: mem_req=%b mem_addr=%h wait=%b, required 1 %h 1",
                 name, k, mem_req, mem_addr, core_wait, {addr[31:2], 2'b00});
      end
      checks++;
      if (mem_ack) begin
        if (valid_w_en !== 1'b1 || tag_w_en !== 1'b1 || data_w_en !== 1'b1 ||
            valid_in !== 1'b1 || tag_in !== addr[31:7] || data_in !== data ||
            ram_index !== addr[6:2]) begin
          errors++;
          $display("FAIL %s_refill_write: we=%b%b%b vin=%b tag=%h data=%h idx=%0d, required 111 1 %h %h %0d",
                   name, valid_w_en, tag_w_en, data_w_en, valid_in, tag_in, data_in,
                   ram_index, addr[31:7], data, addr[6:2]);
        end
      end else if (valid_w_en !== 1'b0 || tag_w_en !== 1'b0 || data_w_en !== 1'b0) begin
        errors++;
        $display("FAIL %s_early_write: we=%b%b%b, required 000",
                 name, valid_w_en, tag_w_en, data_w_en);
      end
    end
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    flush     = 1'b0;
    #1;
    checks++;
    if (core_wait !== 1'b0 || core_rdata !== data || mem_req !== 1'b0 ||
        valid_w_en !== 1'b0 || data_w_en !== 1'b0) begin
      errors++;
      $display("FAIL %s_resp: wait=%b rdata=%h mem_req=%b we=%b%b, required 0 %h 0 00",
               name, core_wait, core_rdata, mem_req, valid_w_en, data_w_en, data);
    end
    core_req = 1'b0;
    checks++;
    if (data_wr_cnt - wr0 !== 1) begin
      errors++;
      $display("FAIL %s_write_count: got %0d data writes, required 1", name, data_wr_cnt - wr0);
    end
  endtask

  task automatic test_hit(input logic [31:0] addr, input logic [31:0] data, input string name);
    @(negedge clk);
    core_req  = 1'b1;
    core_addr = addr;
    #1;
    checks++;
    if (core_wait !== 1'b0 || core_rdata !== data || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_hit: wait=%b rdata=%h mem_req=%b, required 0 %h 0",
               name, core_wait, core_rdata, mem_req, data);
    end
    @(negedge clk);
    core_req = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || core_wait !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_hit: mem_req=%b wait=%b, required 0 0", name, mem_req, core_wait);
    end
  endtask

  // Counts flush_busy cycles over a fixed window and checks the sweep order
  task automatic check_sweep(input int absorb_at, input string name);
    int busy;
    int bad;
    busy = 0;
    bad  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      flush    = (c == absorb_at);
      core_req = (c == 5);
      core_addr = 32'h104;
      #1;
      if (flush_busy === 1'b1) busy++;
      if (c == 5) begin
        checks++;
        if (core_wait !== 1'b1 || flush_busy !== 1'b1) begin
          errors++;
          $display("FAIL %s_stall: wait=%b busy=%b, required 1 1", name, core_wait, flush_busy);
        end
      end
    end
    flush    = 1'b0;
    core_req = 1'b0;
    checks++;
    if (busy != 32) begin
      errors++;
      $display("FAIL %s_length: flush_busy high %0d cycles, required 32", name, busy);
    end
    checks++;
    if (flush_q.size() != 32) begin
      errors++;
      $display("FAIL %s_writes: %0d valid clears, required 32", name, flush_q.size());
    end else begin
      for (int i = 0; i < 32; i++) if (flush_q[i] !== 5'(i)) bad++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s_order: %0d clears out of order, required indices 0..31", name, bad);
      end
    end
  endtask

  task automatic test_cold_miss_and_hit();
    do_miss(32'h40, 32'hDEADBEEF, 3, -1, "cold");
    test_hit(32'h40, 32'hDEADBEEF, "rehit");
  endtask

  task automatic test_conflict();
    do_miss(32'hC0, 32'h12345678, 0, -1, "conflict");
    test_hit(32'hC0, 32'h12345678, "conflict");
    do_miss(32'h40, 32'hDEADBEEF, 1, -1, "evicted");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 32; i++) do_miss(32'h100 + 32'(i * 4), 32'hA500_0000 + 32'(i), 0, -1, "fill");
    test_hit(32'h17C, 32'hA500_001F, "filled");
    flush_q.delete();
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (flush_busy !== 1'b0 || core_wait !== 1'b0) begin
      errors++;
      $display("FAIL flush_start: busy=%b wait=%b, required 0 0", flush_busy, core_wait);
    end
    check_sweep(10, "flush");
    do_miss(32'h40, 32'hCAFEF00D, 2, -1, "postflush");
  endtask

  task automatic test_flush_during_miss();
    flush_q.delete();
    do_miss(32'h200, 32'h0BADCAFE, 1, 1, "pendmiss");
    check_sweep(-1, "pendflush");
    do_miss(32'h200, 32'h55AA55AA, 0, -1, "afterpend");
  endtask

  task automatic test_reset_in_miss();
    int wr0;
    @(negedge clk);
    core_req  = 1'b1;
    core_addr = 32'h300;
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rstmiss_req: mem_req=%b, required 1", mem_req);
    end
    wr0 = data_wr_cnt;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h77777777;
    rst       = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || valid_w_en !== 1'b0 || tag_w_en !== 1'b0 || data_w_en !== 1'b0) begin
      errors++;
      $display("FAIL rstmiss_drop: mem_req=%b we=%b%b%b, required 0 000",
               mem_req, valid_w_en, tag_w_en, data_w_en);
    end
    @(negedge clk);
    rst      = 1'b0;
    mem_ack  = 1'b0;
    core_req = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || core_wait !== 1'b0 || flush_busy !== 1'b0 ||
        core_rdata !== 32'h0 || data_wr_cnt != wr0) begin
      errors++;
      $display("FAIL rstmiss_idle: mem_req=%b wait=%b busy=%b rdata=%h writes=%0d, required 0 0 0 0 0",
               mem_req, core_wait, flush_busy, core_rdata, data_wr_cnt - wr0);
    end
    do_miss(32'h40, 32'h13579BDF, 1, -1, "postrst");
  endtask

  initial begin
    rst       = 1'b1;
    core_req  = 1'b0;
    core_addr = '0;
    flush     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_cold_miss_and_hit();
    test_conflict();
    test_flush();
    test_flush_during_miss();
    test_reset_in_miss();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
